// File: rtl/divider_sched_pkg.sv
// Types and helpers shared by the divider scheduler and its round-robin arbiter.
package divider_sched_pkg;

  // Requester IDs are sized for the largest supported requester count (16).
  localparam int MAX_NUM_REQ = 16;
  localparam int REQ_ID_W    = $clog2(MAX_NUM_REQ);

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
    logic                dbz;
  } div_tag_t;

  function automatic int out_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// One-hot round-robin picker. The search starts at the internal pointer, and
// the pointer moves to winner+1 whenever i_update is high with a grant present.
module rr_arbiter
  import divider_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_update,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_hi_win;
  logic [PTR_W-1:0] w_lo_win;
  logic [PTR_W-1:0] w_win;
  logic             w_hi;
  logic             w_any;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest one.
  always_comb begin
    w_hi     = 1'b0;
    w_hi_win = '0;
    w_lo_win = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        w_lo_win = PTR_W'(j);
        if (PTR_W'(j) >= r_ptr) begin
          w_hi     = 1'b1;
          w_hi_win = PTR_W'(j);
        end
      end
    end
    w_win = w_hi ? w_hi_win : w_lo_win;
    w_any = |i_req;
  end

  assign o_grant    = w_any ? (NUM_REQ'(1) << w_win) : '0;
  assign o_grant_id = w_win;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_update && w_any) begin
      r_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// Shares one free-running pipelined divider among NUM_REQ requesters; a tag
// pipeline running beside the divider routes each result back to its requester.
module divider_scheduler
  import divider_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATAWIDTH       = 8,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]         rsp_q,
  output logic [DATAWIDTH-1:0]         rsp_r,
  output logic                         rsp_dbz,
  output logic                         div_valid,
  output logic [DATAWIDTH-1:0]         div_a,
  output logic [DATAWIDTH-1:0]         div_b,
  input  logic                         div_o_valid,
  input  logic [DATAWIDTH-1:0]         div_q,
  input  logic [DATAWIDTH-1:0]         div_r,
  output logic                         err_tag
);

  localparam int CNT_W  = out_cnt_w(MAX_OUTSTANDING);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int MASK_W = $clog2(LATENCY + 1);

  logic [CNT_W-1:0]     r_outstanding [NUM_REQ];
  div_tag_t             r_tag_pipe [LATENCY+1];
  logic [MASK_W-1:0]    r_mask;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic                 w_accept;
  logic [DATAWIDTH-1:0] w_sel_a;
  logic [DATAWIDTH-1:0] w_sel_b;
  div_tag_t             w_new_tag;
  div_tag_t             w_tail;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] && (r_outstanding[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_req     (w_elig),
    .i_update  (w_accept),
    .o_grant   (w_grant),
    .o_grant_id(w_grant_id)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*DATAWIDTH +: DATAWIDTH];
        w_sel_b = req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_accept;
    w_new_tag.id    = REQ_ID_W'(w_grant_id);
    w_new_tag.dbz   = w_accept && (w_sel_b == '0);
  end

  // Stage 0 lines up with div_valid; stage LATENCY lines up with div_o_valid.
  assign w_tail = r_tag_pipe[LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_valid <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        r_tag_pipe[s] <= '0;
      end
    end else begin
      div_valid <= w_accept;
      if (w_accept) begin
        div_a <= w_sel_a;
        div_b <= w_sel_b;
      end
      r_tag_pipe[0] <= w_new_tag;
      for (int s = 1; s <= LATENCY; s++) begin
        r_tag_pipe[s] <= r_tag_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dbz   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= w_tail.valid && (w_tail.id == REQ_ID_W'(i));
      end
      if (w_tail.valid) begin
        rsp_q   <= div_q;
        rsp_r   <= div_r;
        rsp_dbz <= w_tail.dbz;
      end
    end
  end

  // Retire on the response strobe; a simultaneous accept cancels it out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({w_grant[i], rsp_valid[i]})
          2'b10:   r_outstanding[i] <= r_outstanding[i] + 1'b1;
          2'b01:   r_outstanding[i] <= r_outstanding[i] - 1'b1;
          default: r_outstanding[i] <= r_outstanding[i];
        endcase
      end
    end
  end

  // The divider's own pipeline is still flushing right after reset, so the check waits it out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask  <= MASK_W'(LATENCY);
      err_tag <= 1'b0;
    end else if (r_mask != '0) begin
      r_mask <= r_mask - 1'b1;
    end else if (div_o_valid != w_tail.valid) begin
      err_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler: one instance at LATENCY=1 and one at
// LATENCY=9, each paired with a small behavioural model of the pipelined divider.
module tb_divider_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int L1 = 1;
  localparam int L9 = 9;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst;
  logic force_ov;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [NR-1:0]    req_valid1, req_ready1, rsp_valid1;
  logic [NR*DW-1:0] req_a1, req_b1;
  logic [DW-1:0]    rsp_q1, rsp_r1, div_a1, div_b1, div_q1, div_r1;
  logic             rsp_dbz1, div_valid1, div_o_valid1, err_tag1;

  logic [NR-1:0]    req_valid9, req_ready9, rsp_valid9;
  logic [NR*DW-1:0] req_a9, req_b9;
  logic [DW-1:0]    rsp_q9, rsp_r9, div_a9, div_b9, div_q9, div_r9;
  logic             rsp_dbz9, div_valid9, div_o_valid9, err_tag9;

  divider_scheduler #(.NUM_REQ(NR), .DATAWIDTH(DW), .LATENCY(L1), .MAX_OUTSTANDING(MO)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1),
    .rsp_valid(rsp_valid1), .rsp_q(rsp_q1), .rsp_r(rsp_r1), .rsp_dbz(rsp_dbz1),
    .div_valid(div_valid1), .div_a(div_a1), .div_b(div_b1),
    .div_o_valid(div_o_valid1), .div_q(div_q1), .div_r(div_r1), .err_tag(err_tag1)
  );

  divider_scheduler #(.NUM_REQ(NR), .DATAWIDTH(DW), .LATENCY(L9), .MAX_OUTSTANDING(MO)) u_dut9 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid9), .req_ready(req_ready9), .req_a(req_a9), .req_b(req_b9),
    .rsp_valid(rsp_valid9), .rsp_q(rsp_q9), .rsp_r(rsp_r9), .rsp_dbz(rsp_dbz9),
    .div_valid(div_valid9), .div_a(div_a9), .div_b(div_b9),
    .div_o_valid(div_o_valid9), .div_q(div_q9), .div_r(div_r9), .err_tag(err_tag9)
  );

  // Divider model: divide by zero gives Q = all ones, R = dividend.
  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic logic [DW-1:0] ref_r(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  logic          m1_v [L1];
  logic [DW-1:0] m1_q [L1];
  logic [DW-1:0] m1_r [L1];
  logic          m9_v [L9];
  logic [DW-1:0] m9_q [L9];
  logic [DW-1:0] m9_r [L9];

  always @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < L1; s++) begin
        m1_v[s] <= 1'b0; m1_q[s] <= '0; m1_r[s] <= '0;
      end
      for (int s = 0; s < L9; s++) begin
        m9_v[s] <= 1'b0; m9_q[s] <= '0; m9_r[s] <= '0;
      end
    end else begin
      m1_v[0] <= div_valid1;
      m1_q[0] <= ref_q(div_a1, div_b1);
      m1_r[0] <= ref_r(div_a1, div_b1);
      for (int s = 1; s < L1; s++) begin
        m1_v[s] <= m1_v[s-1]; m1_q[s] <= m1_q[s-1]; m1_r[s] <= m1_r[s-1];
      end
      m9_v[0] <= div_valid9;
      m9_q[0] <= ref_q(div_a9, div_b9);
      m9_r[0] <= ref_r(div_a9, div_b9);
      for (int s = 1; s < L9; s++) begin
        m9_v[s] <= m9_v[s-1]; m9_q[s] <= m9_q[s-1]; m9_r[s] <= m9_r[s-1];
      end
    end
  end

  assign div_o_valid1 = m1_v[L1-1] | force_ov;
  assign div_q1       = m1_q[L1-1];
  assign div_r1       = m1_r[L1-1];
  assign div_o_valid9 = m9_v[L9-1];
  assign div_q9       = m9_q[L9-1];
  assign div_r9       = m9_r[L9-1];

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] rr_q [4];
  int         lat;
  logic [NR-1:0] seen_rsp;
  logic       seen_err;
  logic       err_lost;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{0, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
    vecs[2] = '{1, 8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
    vecs[3] = '{3, 8'd13,  8'd0,   8'hFF,  8'd13,  1'b1};
    vecs[4] = '{2, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[5] = '{0, 8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
    vecs[6] = '{1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[7] = '{3, 8'd128, 8'd255, 8'd0,   8'd128, 1'b0};
    rr_q[0] = 8'd3; rr_q[1] = 8'd6; rr_q[2] = 8'd10; rr_q[3] = 8'd13;

    rst = 1'b0; force_ov = 1'b0;
    req_valid1 = '0; req_a1 = '0; req_b1 = '0;
    req_valid9 = '0; req_a9 = '0; req_b9 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_rsp_q", rsp_q1, 0);
    check("rst_rsp_r", rsp_r1, 0);
    check("rst_rsp_dbz", rsp_dbz1, 0);
    check("rst_div_valid", div_valid1, 0);
    check("rst_div_a", div_a1, 0);
    check("rst_div_b", div_b1, 0);
    check("rst_err_tag", err_tag1, 0);
    check("rst_req_ready", req_ready1, 0);
    check("rst9_rsp_valid", rsp_valid9, 0);
    check("rst9_rsp_dbz", rsp_dbz9, 0);
    check("rst9_div_valid", div_valid9, 0);
    check("rst9_err_tag", err_tag9, 0);
    rst = 1'b1;

    // Single requests: one-hot ready, latency of 3, routed result.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_a1[vecs[i].id*DW +: DW] = vecs[i].a;
      req_b1[vecs[i].id*DW +: DW] = vecs[i].b;
      req_valid1 = NR'(1 << vecs[i].id);
      #1;
      check($sformatf("vec%0d_ready", i), req_ready1, 1 << vecs[i].id);
      @(posedge clk);
      #1;
      req_valid1 = '0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (lat == 0 && rsp_valid1 != '0) begin
          lat = k;
          check($sformatf("vec%0d_rsp_id", i), rsp_valid1, 1 << vecs[i].id);
          check($sformatf("vec%0d_q", i), rsp_q1, vecs[i].q);
          check($sformatf("vec%0d_r", i), rsp_r1, vecs[i].r);
          check($sformatf("vec%0d_dbz", i), rsp_dbz1, vecs[i].dbz);
        end
      end
      check($sformatf("vec%0d_latency", i), lat, 3);
    end
    check("vec_no_err_tag", err_tag1, 0);

    // Round-robin with all four requesters valid for 64 cycles.
    do_reset();
    req_a1 = {8'd40, 8'd30, 8'd20, 8'd10};
    req_b1 = {4{8'd3}};
    @(negedge clk);
    req_valid1 = 4'hF;
    #1;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("rr_grant", req_ready1, 1 << (k % 4));
      if (k >= 3) begin
        check("rr_rsp_id", rsp_valid1, 1 << ((k - 3) % 4));
        check("rr_rsp_q", rsp_q1, rr_q[(k - 3) % 4]);
      end
    end
    @(posedge clk);
    #1;
    req_valid1 = '0;
    repeat (6) @(negedge clk);

    // Outstanding limit at LATENCY=9: two accepts, stall, re-eligible after first response.
    do_reset();
    req_a9[7:0] = 8'd99;
    req_b9[7:0] = 8'd9;
    @(negedge clk);
    req_valid9 = 4'b0001;
    #1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("lim_ready_c%0d", k), req_ready9, (k < 2 || k == 12) ? 1 : 0);
      check($sformatf("lim_rsp_c%0d", k), rsp_valid9, (k == 11 || k == 12) ? 1 : 0);
      if (k == 11) begin
        check("lim_q", rsp_q9, 11);
        check("lim_r", rsp_r9, 0);
      end
    end
    @(posedge clk);
    #1;
    req_valid9 = '0;
    repeat (14) @(negedge clk);

    // Reset with three operations in flight.
    req_a9 = {8'd80, 8'd60, 8'd40, 8'd20};
    req_b9 = {4{8'd2}};
    @(negedge clk);
    req_valid9 = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    req_valid9 = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen_rsp = '0;
    seen_err = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_rsp |= rsp_valid9;
      seen_err |= err_tag9;
    end
    check("rst_flight_no_rsp", seen_rsp, 0);
    check("rst_flight_no_err", seen_err, 0);
    @(negedge clk);
    req_valid9 = 4'hF;
    #1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("rst_grant_c%0d", k), req_ready9, (k < 8) ? (1 << (k % 4)) : 0);
    end
    @(posedge clk);
    #1;
    req_valid9 = '0;
    repeat (14) @(negedge clk);

    // Spurious divider valid while the tail tag is empty.
    @(negedge clk);
    check("err_pre", err_tag1, 0);
    force_ov = 1'b1;
    @(negedge clk);
    force_ov = 1'b0;
    check("err_set", err_tag1, 1);
    check("err_no_rsp", rsp_valid1, 0);
    seen_rsp = '0;
    err_lost = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_rsp |= rsp_valid1;
      if (err_tag1 !== 1'b1) err_lost = 1'b1;
    end
    check("err_sticky", err_lost, 0);
    check("err_no_rsp_after", seen_rsp, 0);
    check("err_other_inst", err_tag9, 0);
    do_reset();
    @(negedge clk);
    check("err_cleared", err_tag1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
